// File: rtl/mm_mac_sequencer_if.sv
// Operand, result and handshake bundle for mm_mac_sequencer.
// start is sampled only when ready=1; busy/done/C_* and dbg_state are DUT-driven.
interface mm_mac_sequencer_if #(
  parameter int NBITS        = 8,
  parameter int RESULT_WIDTH = 2 * NBITS
);
  logic                    start;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic [1:0]              dbg_state;
  logic [NBITS-1:0]        A_11, A_12, A_13;
  logic [NBITS-1:0]        A_21, A_22, A_23;
  logic [NBITS-1:0]        A_31, A_32, A_33;
  logic [NBITS-1:0]        B_11, B_21, B_31;
  logic [RESULT_WIDTH-1:0] C_11, C_21, C_31;

  modport master (
    output start, A_11, A_12, A_13, A_21, A_22, A_23, A_31, A_32, A_33,
           B_11, B_21, B_31,
    input  ready, busy, done, dbg_state, C_11, C_21, C_31
  );

  modport slave (
    input  start, A_11, A_12, A_13, A_21, A_22, A_23, A_31, A_32, A_33,
           B_11, B_21, B_31,
    output ready, busy, done, dbg_state, C_11, C_21, C_31
  );
endinterface

// File: rtl/mm_mac_sequencer.sv
// 3x3 by 3x1 matrix-vector multiply using one time-shared multiplier, nine MAC steps.
// Optional MM_SATURATE_EN: accumulate saturates to all-ones instead of wrapping.
module mm_mac_sequencer #(
  parameter int NBITS        = 8,
  parameter int RESULT_WIDTH = 2 * NBITS
) (
  input logic                  clk,
  input logic                  rst_n,
  mm_mac_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [3:0]                         k_q, k_d;
  logic [RESULT_WIDTH-1:0]            acc_q, acc_d;
  logic [1:0][RESULT_WIDTH-1:0]       row_q, row_d;
  logic [8:0][NBITS-1:0]              a_q, a_d;
  logic [2:0][NBITS-1:0]              b_q, b_d;
  logic [2:0][RESULT_WIDTH-1:0]       c_q, c_d;

  logic                    ready_o, busy_o, done_o;
  logic [1:0]              col;
  logic [NBITS-1:0]        mul_a, mul_b;
  logic [2*NBITS-1:0]      prod;
  logic [RESULT_WIDTH-1:0] acc_next;
  logic                    accept;

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    col = 2'd0;
    case (k_q)
      4'd1, 4'd4, 4'd7: col = 2'd1;
      4'd2, 4'd5, 4'd8: col = 2'd2;
      default:          col = 2'd0;
    endcase
  end

  // The single shared multiplier: A[k/3][k%3] * B[k%3].
  assign mul_a = a_q[k_q];
  assign mul_b = b_q[col];
  assign prod  = (2*NBITS)'(mul_a) * (2*NBITS)'(mul_b);

`ifdef MM_SATURATE_EN
  logic [RESULT_WIDTH:0] sum_wide;
  assign sum_wide = {1'b0, acc_q} + {1'b0, RESULT_WIDTH'(prod)};
  assign acc_next = sum_wide[RESULT_WIDTH] ? '1 : sum_wide[RESULT_WIDTH-1:0];
`else
  assign acc_next = acc_q + RESULT_WIDTH'(prod);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (k_q == 4'd8) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state_q == IDLE);
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
  end

  always_comb begin
    k_d   = k_q;
    acc_d = acc_q;
    row_d = row_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    if (accept) begin
      a_d   = {bus.A_33, bus.A_32, bus.A_31, bus.A_23, bus.A_22, bus.A_21,
               bus.A_13, bus.A_12, bus.A_11};
      b_d   = {bus.B_31, bus.B_21, bus.B_11};
      acc_d = '0;
      k_d   = 4'd0;
    end else if (state_q == MAC) begin
      k_d   = k_q + 4'd1;
      acc_d = acc_next;
      if (k_q == 4'd2) begin
        row_d[0] = acc_next;
        acc_d    = '0;
      end
      if (k_q == 4'd5) begin
        row_d[1] = acc_next;
        acc_d    = '0;
      end
      // Last row never needs a register: it lands in C with the other two.
      if (k_q == 4'd8) begin
        c_d   = {acc_next, row_q[1], row_q[0]};
        acc_d = '0;
        k_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      acc_q <= '0;
      row_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
      row_q <= row_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
    end
  end

  assign bus.ready     = ready_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.dbg_state = state_q;
  assign bus.C_11      = c_q[0];
  assign bus.C_21      = c_q[1];
  assign bus.C_31      = c_q[2];
endmodule

// File: tb/tb_mm_mac_sequencer.sv
// Scenario-driven bench for mm_mac_sequencer: operations queue their expected C vector,
// which is popped and compared when done pulses.
module tb_mm_mac_sequencer;
  localparam int NB = 8;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mm_mac_sequencer_if #(.NBITS(NB), .RESULT_WIDTH(RW)) bus ();

  mm_mac_sequencer #(.NBITS(NB), .RESULT_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [3*RW-1:0] exp_q[$];
  logic [3*RW-1:0] last_c;

  function automatic logic [3*RW-1:0] c_now();
    return {bus.C_31, bus.C_21, bus.C_11};
  endfunction

  // Reference: row-by-row dot products with the same overflow rule as the build.
  function automatic logic [3*RW-1:0] model(input logic [8:0][NB-1:0] a,
                                            input logic [2:0][NB-1:0] b);
    logic [2:0][RW-1:0] c;
    logic [RW-1:0]      acc;
    logic [RW:0]        s;
    logic [2*NB-1:0]    p;
    c = '0;
    for (int r = 0; r < 3; r++) begin
      acc = '0;
      for (int j = 0; j < 3; j++) begin
        p = (2*NB)'(a[r*3+j]) * (2*NB)'(b[j]);
        s = {1'b0, acc} + {1'b0, RW'(p)};
`ifdef MM_SATURATE_EN
        acc = s[RW] ? '1 : s[RW-1:0];
`else
        acc = s[RW-1:0];
`endif
      end
      c[r] = acc;
    end
    return c;
  endfunction

  task automatic set_ops(input logic [8:0][NB-1:0] a, input logic [2:0][NB-1:0] b);
    bus.A_11 = a[0]; bus.A_12 = a[1]; bus.A_13 = a[2];
    bus.A_21 = a[3]; bus.A_22 = a[4]; bus.A_23 = a[5];
    bus.A_31 = a[6]; bus.A_32 = a[7]; bus.A_33 = a[8];
    bus.B_11 = b[0]; bus.B_21 = b[1]; bus.B_31 = b[2];
  endtask

  task automatic scramble_ops();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(0, 255));
    set_ops(a, b);
  endtask

  // Called at a negedge; accepts on the following rising edge.
  task automatic accept_op(input logic [8:0][NB-1:0] a, input logic [2:0][NB-1:0] b,
                           input bit keep_start);
    set_ops(a, b);
    bus.start = 1'b1;
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready got=%b want=1", bus.ready);
    end
    exp_q.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    if (!keep_start) bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_busy got=%b want=1", bus.busy);
    end
  endtask

  task automatic wait_done(input bit scramble);
    int lat;
    bit c_held;
    logic [3*RW-1:0] exp;
    lat = 0;
    c_held = 1'b1;
    while (bus.done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (bus.done !== 1'b1 && c_now() !== last_c) c_held = 1'b0;
      if (scramble) scramble_ops();
    end
    checks++;
    if (bus.done !== 1'b1 || lat != 9) begin
      failures++;
      $display("FAIL done_latency got=%0d done=%b want=9", lat, bus.done);
    end
    checks++;
    if (!c_held) begin
      failures++;
      $display("FAIL c_hold got=changed_before_done want=held_at_%h", last_c);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL result got=%h want=queued_entry", c_now());
    end else begin
      exp = exp_q.pop_front();
      if (c_now() !== exp) begin
        failures++;
        $display("FAIL result got=%h want=%h", c_now(), exp);
      end
      last_c = exp;
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL post_done got=done%b ready%b busy%b want=done0 ready1 busy0",
               bus.done, bus.ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_ops('0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", bus.ready); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", bus.done); end
    checks++;
    if (c_now() !== '0) begin failures++; $display("FAIL rst_c got=%h want=0", c_now()); end
    checks++;
    if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d want=0", bus.dbg_state); end
    last_c = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    logic [3*RW-1:0] want;
    a = '0; a[0] = 8'd1; a[4] = 8'd1; a[8] = 8'd1;
    b[0] = 8'd1; b[1] = 8'd2; b[2] = 8'd3;
    want = {16'd3, 16'd2, 16'd1};
    accept_op(a, b, 1'b0);
    wait_done(1'b0);
    checks++;
    if (c_now() !== want) begin failures++; $display("FAIL identity got=%h want=%h", c_now(), want); end
  endtask

  task automatic test_general();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    logic [3*RW-1:0] want;
    for (int i = 0; i < 9; i++) a[i] = NB'(i + 1);
    b[0] = 8'd1; b[1] = 8'd1; b[2] = 8'd1;
    want = {16'd24, 16'd15, 16'd6};
    accept_op(a, b, 1'b0);
    wait_done(1'b1);
    checks++;
    if (c_now() !== want) begin failures++; $display("FAIL general got=%h want=%h", c_now(), want); end
  endtask

  task automatic test_overflow();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    logic [RW-1:0] one;
    for (int i = 0; i < 9; i++) a[i] = 8'd255;
    for (int i = 0; i < 3; i++) b[i] = 8'd255;
`ifdef MM_SATURATE_EN
    one = 16'd65535;
`else
    one = 16'd64003;
`endif
    accept_op(a, b, 1'b0);
    wait_done(1'b0);
    checks++;
    if (c_now() !== {one, one, one}) begin
      failures++;
      $display("FAIL overflow got=%h want=%h", c_now(), {one, one, one});
    end
  endtask

  task automatic test_start_held();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(0, 255));
    accept_op(a, b, 1'b1);
    wait_done(1'b1);
    for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(0, 255));
    accept_op(a, b, 1'b0);
    wait_done(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(1, 255));
    for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(1, 255));
    accept_op(a, b, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (c_now() !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got=c%h done%b busy%b ready%b want=c0 done0 busy0 ready1",
               c_now(), bus.done, bus.busy, bus.ready);
    end
    void'(exp_q.pop_back());
    last_c = '0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_no_done got=%b want=0", bus.done); end
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(0, 255));
    accept_op(a, b, 1'b0);
    wait_done(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [8:0][NB-1:0] a;
    logic [2:0][NB-1:0] b;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 9; i++) a[i] = NB'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++) b[i] = NB'($urandom_range(0, 255));
      accept_op(a, b, 1'b0);
      wait_done(n[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_identity();
    test_general();
    test_overflow();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
